// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Oversampling-free 8N1-style serial receiver with mid-bit sampling
//             and a valid/ready output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 9600,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rxif_sig,
  output logic [DATA_WIDTH-1:0] rxif_data,
  output logic                  rxif_valid,
  input  logic                  rxif_ready
);

  localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
  localparam int HALF        = PULSE_WIDTH / 2;
  localparam int CNT_W       = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam int IDX_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                r_state, w_state_next;
  logic                  r_sync1, r_sync2;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_shift;

  logic w_cnt_clr, w_idx_clr, w_shift_en, w_frame_ok;

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_idx_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_frame_ok   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (!r_sync2) w_state_next = START;
      end
      START: begin
        if (r_cnt == C_CNT_HALF) begin
          w_cnt_clr    = 1'b1;
          w_idx_clr    = 1'b1;
          // A line already back high at mid start bit was only a glitch.
          w_state_next = r_sync2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == C_CNT_FULL) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_idx == C_IDX_LAST) w_state_next = STOP;
        end
      end
      STOP: begin
        if (r_cnt == C_CNT_FULL) begin
          w_cnt_clr    = 1'b1;
          w_frame_ok   = r_sync2;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state    <= IDLE;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      rxif_data  <= '0;
      rxif_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sync1 <= rxif_sig;
      r_sync2 <= r_sync1;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_shift_en) begin
        r_shift[r_idx] <= r_sync2;
        r_idx          <= r_idx + IDX_W'(1);
      end
      // A completing frame takes priority over an acceptance in the same cycle.
      if (w_frame_ok) begin
        rxif_data  <= r_shift;
        rxif_valid <= 1'b1;
      end else if (rxif_valid && rxif_ready) begin
        rxif_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Directed self-checking bench for uart_rx at a reduced bit time.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int DATA_WIDTH  = 8;
  localparam int CLK_FREQ    = 160;
  localparam int BAUD_RATE   = 10;
  localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;   // 16
  localparam int HALF        = PULSE_WIDTH / 2;        // 8

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  rxif_sig;
  logic [DATA_WIDTH-1:0] rxif_data;
  logic                  rxif_valid;
  logic                  rxif_ready;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx #(
    .DATA_WIDTH (DATA_WIDTH),
    .BAUD_RATE  (BAUD_RATE),
    .CLK_FREQ   (CLK_FREQ)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rxif_sig   (rxif_sig),
    .rxif_data  (rxif_data),
    .rxif_valid (rxif_valid),
    .rxif_ready (rxif_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxif_sig = 1'b0;
    repeat (PULSE_WIDTH) tick();
    for (int i = 0; i < DATA_WIDTH; i++) begin
      rxif_sig = b[i];
      repeat (PULSE_WIDTH) tick();
    end
    rxif_sig = stop_bit;
    repeat (PULSE_WIDTH) tick();
    rxif_sig = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 4 * PULSE_WIDTH && !rxif_valid; i++) tick();
    check(tag, {31'd0, rxif_valid}, 32'd1);
  endtask

  task automatic pulse_ready(input string tag);
    rxif_ready = 1'b1;
    tick();
    rxif_ready = 1'b0;
    check(tag, {31'd0, rxif_valid}, 32'd0);
  endtask

  initial begin
    rstn       = 1'b1;
    rxif_sig   = 1'b1;
    rxif_ready = 1'b0;
    repeat (3) tick();
    rstn = 1'b0;
    check("reset_valid", {31'd0, rxif_valid}, 32'd0);
    check("reset_data", {24'd0, rxif_data}, 32'h00);
    repeat (4) tick();

    // Full byte sweep with randomized consumer delay.
    for (int b = 0; b < 256; b++) begin
      send_frame(8'(b), 1'b1);
      wait_valid("sweep_valid");
      check("sweep_data", {24'd0, rxif_data}, b);
      repeat ($urandom_range(PULSE_WIDTH, HALF)) tick();
      check("sweep_data_held", {24'd0, rxif_data}, b);
      pulse_ready("sweep_valid_drop");
    end
    repeat (PULSE_WIDTH) tick();

    // Hold with ready low.
    send_frame(8'hA5, 1'b1);
    wait_valid("hold_valid");
    repeat (5 * PULSE_WIDTH) tick();
    check("hold_valid_kept", {31'd0, rxif_valid}, 32'd1);
    check("hold_data", {24'd0, rxif_data}, 32'hA5);
    pulse_ready("hold_valid_drop");
    check("hold_data_after", {24'd0, rxif_data}, 32'hA5);

    // False start shorter than half a bit.
    repeat (PULSE_WIDTH) tick();
    rxif_sig = 1'b0;
    repeat (HALF / 2) tick();
    rxif_sig = 1'b1;
    repeat (2 * PULSE_WIDTH) tick();
    check("glitch_no_valid", {31'd0, rxif_valid}, 32'd0);
    check("glitch_data", {24'd0, rxif_data}, 32'hA5);
    send_frame(8'h3C, 1'b1);
    wait_valid("glitch_next_valid");
    check("glitch_next_data", {24'd0, rxif_data}, 32'h3C);
    pulse_ready("glitch_next_drop");

    // Framing error: stop bit low.
    repeat (PULSE_WIDTH) tick();
    send_frame(8'h55, 1'b0);
    repeat (2 * PULSE_WIDTH) tick();
    check("frame_err_no_valid", {31'd0, rxif_valid}, 32'd0);
    check("frame_err_data", {24'd0, rxif_data}, 32'h3C);
    send_frame(8'h81, 1'b1);
    wait_valid("frame_next_valid");
    check("frame_next_data", {24'd0, rxif_data}, 32'h81);
    pulse_ready("frame_next_drop");

    // Reset during bit 4 of a 0xFF frame.
    repeat (PULSE_WIDTH) tick();
    rxif_sig = 1'b0;
    repeat (PULSE_WIDTH) tick();
    rxif_sig = 1'b1;
    repeat (4 * PULSE_WIDTH + HALF / 2) tick();
    rstn = 1'b1;
    repeat (2) tick();
    rstn = 1'b0;
    check("rst_mid_valid", {31'd0, rxif_valid}, 32'd0);
    check("rst_mid_data", {24'd0, rxif_data}, 32'h00);
    repeat (8 * PULSE_WIDTH) tick();
    check("rst_mid_no_late_valid", {31'd0, rxif_valid}, 32'd0);
    send_frame(8'h12, 1'b1);
    wait_valid("rst_next_valid");
    check("rst_next_data", {24'd0, rxif_data}, 32'h12);
    pulse_ready("rst_next_drop");

    // Overrun: two frames with ready held low.
    repeat (PULSE_WIDTH) tick();
    send_frame(8'h11, 1'b1);
    wait_valid("ovr_first_valid");
    check("ovr_first_data", {24'd0, rxif_data}, 32'h11);
    send_frame(8'h22, 1'b1);
    repeat (PULSE_WIDTH) tick();
    check("ovr_valid_kept", {31'd0, rxif_valid}, 32'd1);
    check("ovr_data", {24'd0, rxif_data}, 32'h22);
    pulse_ready("ovr_drop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
